// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default bit timing
// common to both the transmitter and the receiver.
package uart_pkg;

  localparam int unsigned BAUD_DIV_DEF = 2605;
  localparam int unsigned HALF_DIV_DEF = 1302;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous input, with a
// parameterized reset value so an idle-high line reads idle out of reset.
module sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rcv.sv
// 8N1 UART receiver: start-edge detect, mid-bit sampling, LSB-first shift,
// stop-bit framing check, and a sticky ready flag for the consumer.
module uart_rcv
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV = BAUD_DIV_DEF,
  parameter int unsigned HALF_DIV = HALF_DIV_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RX,
  input  logic       clr_rdy,
  output logic [7:0] rx_data,
  output logic       rdy,
  output logic       frm_err
);

  // The counter expires on zero, so loading N-1 gives an N-cycle interval.
  localparam logic [11:0] BAUD_RELOAD = 12'(BAUD_DIV - 1);
  localparam logic [11:0] HALF_RELOAD = 12'(HALF_DIV - 1);

  rx_state_t   state;
  logic [11:0] baud_cnt;
  logic [3:0]  bit_cnt;
  logic [7:0]  shift;
  logic        rx_s;
  logic        rx_prev;
  logic        baud_expired;

  sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (RX),
    .q   (rx_s)
  );

  always_comb baud_expired = (baud_cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      rx_prev  <= 1'b1;
      rx_data  <= '0;
      rdy      <= 1'b0;
      frm_err  <= 1'b0;
    end else begin
      rx_prev <= rx_s;

      if (clr_rdy)
        rdy <= 1'b0;

      if (state != IDLE)
        baud_cnt <= baud_expired ? BAUD_RELOAD : baud_cnt - 12'd1;

      case (state)
        IDLE: begin
          if (rx_prev && !rx_s) begin
            state    <= START;
            baud_cnt <= HALF_RELOAD;
            bit_cnt  <= '0;
            rdy      <= 1'b0;
          end
        end
        START: begin
          if (baud_expired)
            state <= rx_s ? IDLE : DATA;
        end
        DATA: begin
          if (baud_expired) begin
            shift   <= {rx_s, shift[7:1]};
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7)
              state <= STOP;
          end
        end
        STOP: begin
          // Placed after the clr_rdy clear so a coincident set takes priority.
          if (baud_expired) begin
            rx_data <= shift;
            rdy     <= 1'b1;
            frm_err <= ~rx_s;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rcv.sv
// Randomized self-checking bench for uart_rcv: frames are driven serially and
// each ready pulse is matched against a queue of expected (byte, framing) results.
module tb_uart_rcv;

  localparam int unsigned BD = 16;
  localparam int unsigned HD = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       RX = 1'b1;
  logic       clr_rdy = 1'b0;
  logic [7:0] rx_data;
  logic       rdy;
  logic       frm_err;

  uart_rcv #(.BAUD_DIV(BD), .HALF_DIV(HD)) dut (
    .clk     (clk),
    .rst     (rst),
    .RX      (RX),
    .clr_rdy (clr_rdy),
    .rx_data (rx_data),
    .rdy     (rdy),
    .frm_err (frm_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [7:0] data;
    logic       ferr;
  } frame_t;

  frame_t      exp_q[$];
  int unsigned cyc = 0;
  int unsigned n_rx = 0;
  int unsigned n_tx = 0;
  int unsigned rise_cyc = 0;
  logic        rdy_q = 1'b0;

  always @(posedge clk) cyc++;

  // Every rising edge of rdy must correspond to the oldest outstanding frame.
  always @(negedge clk) begin
    frame_t f;
    if (rst) begin
      rdy_q = 1'b0;
    end else begin
      if (rdy && !rdy_q) begin
        n_rx++;
        rise_cyc = cyc;
        check("rdy_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          f = exp_q.pop_front();
          check("rx_data", 32'(rx_data), 32'(f.data));
          check("frm_err", 32'(frm_err), 32'(f.ferr));
        end
      end
      rdy_q = rdy;
    end
  end

  task automatic send_frame(input logic [7:0] d, input logic stop_bit,
                            input int unsigned idle_bits, input bit chk_rdy);
    frame_t f;
    f.data = d;
    f.ferr = ~stop_bit;
    exp_q.push_back(f);
    n_tx++;
    RX = 1'b0;
    repeat (BD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RX = d[i];
      repeat (BD) @(negedge clk);
    end
    RX = stop_bit;
    repeat (BD) @(negedge clk);
    if (chk_rdy)
      check("rdy_at_stop_end", 32'(rdy), 32'd1);
    RX = 1'b1;
    repeat (idle_bits * BD) @(negedge clk);
  endtask

  initial begin
    logic [7:0]  abort_byte;
    int unsigned t0;
    logic [7:0]  rd;
    logic        rstop;
    int unsigned ridle;

    repeat (3) @(negedge clk);
    check("reset_rx_data", 32'(rx_data), 32'h00);
    check("reset_rdy", 32'(rdy), 32'd0);
    check("reset_frm_err", 32'(frm_err), 32'd0);
    rst = 1'b0;
    repeat (2 * BD) @(negedge clk);

    // Short low glitch: shorter than half a bit, must be rejected.
    RX = 1'b0;
    repeat (HD - 4) @(negedge clk);
    RX = 1'b1;
    repeat (2 * BD) @(negedge clk);
    check("false_start_rdy", 32'(rdy), 32'd0);
    check("false_start_data", 32'(rx_data), 32'h00);

    t0 = cyc;
    send_frame(8'hA5, 1'b1, 1, 1'b1);
    check("a5_latency", 32'((rise_cyc - t0) <= 10 * BD + 4), 32'd1);

    send_frame(8'h3C, 1'b0, 2, 1'b1);

    send_frame(8'h00, 1'b1, 0, 1'b1);
    send_frame(8'hFF, 1'b1, 0, 1'b1);
    send_frame(8'h55, 1'b1, 2, 1'b1);

    // Abort 0x81 in the middle of data bit 4; the line returns to idle with reset.
    abort_byte = 8'h81;
    RX = 1'b0;
    repeat (BD) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      RX = abort_byte[i];
      repeat (BD) @(negedge clk);
    end
    RX = abort_byte[4];
    repeat (BD / 2) @(negedge clk);
    rst = 1'b1;
    RX = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_rx_data", 32'(rx_data), 32'h00);
    check("abort_rdy", 32'(rdy), 32'd0);
    check("abort_frm_err", 32'(frm_err), 32'd0);
    rst = 1'b0;
    repeat (2 * BD) @(negedge clk);
    check("abort_no_rdy", 32'(rdy), 32'd0);
    send_frame(8'h81, 1'b1, 1, 1'b1);

    fork
      send_frame(8'h7E, 1'b1, 1, 1'b0);
      begin
        bit found;
        found = 1'b0;
        repeat (9 * BD) @(negedge clk);
        clr_rdy = 1'b1;
        for (int i = 0; i < 2 * BD && !found; i++) begin
          @(negedge clk);
          if (rdy) found = 1'b1;
        end
        clr_rdy = 1'b0;
        check("clr_set_wins", 32'(found), 32'd1);
        @(negedge clk);
        check("rdy_hold", 32'(rdy), 32'd1);
        clr_rdy = 1'b1;
        @(negedge clk);
        check("rdy_cleared", 32'(rdy), 32'd0);
        clr_rdy = 1'b0;
      end
    join

    // Break: line held low well past a full frame, then released.
    begin
      frame_t f;
      f.data = 8'h00;
      f.ferr = 1'b1;
      exp_q.push_back(f);
      n_tx++;
    end
    RX = 1'b0;
    repeat (12 * BD) @(negedge clk);
    RX = 1'b1;
    repeat (3 * BD) @(negedge clk);
    check("break_single_frame", n_rx, n_tx);
    send_frame(8'h5A, 1'b1, 1, 1'b1);

    for (int n = 0; n < 24; n++) begin
      rd    = 8'($urandom);
      rstop = ($urandom_range(0, 5) != 0);
      ridle = rstop ? $urandom_range(0, 2) : $urandom_range(1, 2);
      send_frame(rd, rstop, ridle, 1'b1);
    end

    repeat (2 * BD) @(negedge clk);
    check("pending_frames", 32'(exp_q.size()), 32'd0);
    check("rx_count", n_rx, n_tx);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_rcv.md
UART_RCV -- requirements
Module: uart_rcv

Interface
REQ-001 Parameter BAUD_DIV, default 2605: clock cycles per bit period, matching the transmitter.
REQ-002 Parameter HALF_DIV, default 1302: cycles from start-edge detection to the start-bit midpoint.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 RX  input  1  serial line, idle high; asynchronous to clk.
REQ-006 clr_rdy  input  1  consumer acknowledge; clears rdy.
REQ-007 rx_data  output  8  last received byte, LSB received first.
REQ-008 rdy  output  1  byte available in rx_data; level until cleared.
REQ-009 frm_err  output  1  last frame's stop bit sampled low; valid while rdy=1.

Function
REQ-010 RX shall pass through a 2-flop synchronizer preset to 1; all decisions use the synchronized value (rx_s).
REQ-011 FSM states: IDLE, START, DATA, STOP.
REQ-012 IDLE: a falling edge on rx_s (prev 1, now 0) shall enter START and load the baud counter for HALF_DIV.
REQ-013 START: at the half-bit expiry, rx_s=0 shall enter DATA; rx_s=1 is a false start and shall return to IDLE with no output change.
REQ-014 DATA: every BAUD_DIV cycles, shift rx_s into the MSB of the shift register, which shifts right; after the 8th sample, enter STOP.
REQ-015 STOP: after BAUD_DIV cycles, sample rx_s; load rx_data from the shift register, set rdy=1, set frm_err=~rx_s, and return to IDLE.
REQ-016 rx_data, rdy and frm_err shall update in the same cycle, one clock after the stop-bit sample.
REQ-017 The bit counter shall be 4 bits, cleared on START entry, and incremented per data sample; terminal count 8.
REQ-018 The baud counter shall be 12 bits, count down to zero, reload on each expiry, and hold in IDLE.
REQ-019 rdy shall clear on clr_rdy=1, or on START entry for a new frame; rx_data shall hold until the next stop sample.
REQ-020 If clr_rdy=1 coincides with a rdy set event, the set shall win (rdy=1).
REQ-021 A new frame beginning while rdy=1 shall be received normally and overwrite rx_data (no overrun flag).
REQ-022 A line held low (break) shall produce one frame with rx_data=0x00 and frm_err=1, then stay in IDLE until rx_s goes high and falls again.
REQ-023 Back-to-back frames shall be accepted with zero idle bits after the stop bit.

Reset
REQ-024 While rst=1: state=IDLE, rx_data=0x00, rdy=0, frm_err=0, counters=0, synchronizer flops=1.
REQ-025 Reset asserted mid-frame shall abort the frame; no rdy follows deassertion unless a fresh falling edge arrives.

Structure
REQ-026 Package uart_pkg shall hold the rx state enum and the default BAUD_DIV/HALF_DIV constants shared with the transmitter.
REQ-027 The synchronizer shall be a sub-module named sync2, with reset value parameterized.
REQ-028 The baud counter, bit counter, shift register and FSM shall be in uart_rcv.

Verification
REQ-029 Loopback with the transmitter, tx_data=0xA5 -> rdy=1, rx_data=0xA5, frm_err=0, with rdy within 10*BAUD_DIV+4 cycles of trmt.
REQ-030 RX low pulse of 500 cycles, then high -> false start, rdy stays 0, FSM returns to IDLE.
REQ-031 Frame 0x3C with the stop bit driven low -> rdy=1, rx_data=0x3C, frm_err=1.
REQ-032 Back-to-back frames 0x00, 0xFF, 0x55 with no clr_rdy -> rx_data shows each value in turn, and rdy is low only between each START entry and the next stop sample.
REQ-033 rst pulsed at data bit 4 of 0x81 -> outputs all zero, no rdy; the following frame 0x81 is received correctly.
REQ-034 clr_rdy held at 1 in the cycle rdy would set for 0x7E -> rdy=1 after that cycle, then 0 one cycle after clr_rdy is applied again.
